// File: rtl/rtc_burst_reader.sv
// RTC burst read sequencer: reads NUM_REGS RTC registers over the a_d/cs/rd/wr bus into RAM.
// Optional per-nibble BCD check of captured bytes when RTC_BCD_CHECK_EN is defined.
module rtc_burst_reader #(
  parameter int unsigned NUM_REGS     = 3,
  parameter int unsigned BASE_ADDR    = 'h21,
  parameter int unsigned RAM_BASE     = 0,
  parameter int unsigned RAM_AW       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned PHASE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              bcd_err
);

  localparam int unsigned MAX_CYC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP1, S_DATA, S_STORE, S_GAP2, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   ad_out_q, ad_out_d;
  logic                ad_oe_q, ad_oe_d;
  logic                a_d_q, a_d_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic                busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  // Next state, counters and RAM write; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_ADDR;
          idx_d   = '0;
        end
      end
      S_ADDR: if (cnt_q == CNT_W'(PHASE_CYCLES - 1)) begin
        state_d = S_GAP1;
        cnt_d   = '0;
      end
      S_GAP1: if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: if (cnt_q == CNT_W'(PHASE_CYCLES - 1)) begin
        state_d     = S_STORE;
        cnt_d       = '0;
        ram_we_d    = 1'b1;
        ram_addr_d  = RAM_AW'(RAM_BASE) + RAM_AW'(idx_q);
        ram_wdata_d = ad_in;
      end
      S_STORE: begin
        state_d = S_GAP2;
        cnt_d   = '0;
      end
      S_GAP2: if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
        cnt_d = '0;
        if (idx_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ADDR;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything except the write already on the RAM port during STORE.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d     = S_DONE;
      cnt_d       = '0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      aborted_d   = 1'b1;
    end
  end

  always_comb begin
    ad_out_d = ad_out_q;
    ad_oe_d  = 1'b0;
    a_d_d    = 1'b1;
    cs_d     = 1'b1;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    case (state_d)
      S_ADDR: begin
        cs_d     = 1'b0;
        a_d_d    = 1'b0;
        wr_d     = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = DATA_W'(BASE_ADDR) + DATA_W'(idx_d);
      end
      S_DATA: begin
        cs_d = 1'b0;
        rd_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      a_d_q       <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      a_d_q       <= a_d_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef RTC_BCD_CHECK_EN
  logic bcd_bad_c;
  logic bcd_err_q, bcd_err_d;

  always_comb begin
    bcd_bad_c = 1'b0;
    for (int unsigned n = 0; n < DATA_W / 4; n++) begin
      if (ad_in[4*n +: 4] > 4'd9) bcd_bad_c = 1'b1;
    end
  end

  // Sticky until the next accepted start; checked only on bytes actually written.
  always_comb begin
    bcd_err_d = bcd_err_q;
    if ((state_q == S_IDLE) && start) bcd_err_d = 1'b0;
    else if (ram_we_d && bcd_bad_c) bcd_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcd_err_q <= 1'b0;
    else       bcd_err_q <= bcd_err_d;
  end

  assign bcd_err = bcd_err_q;
`else
  assign bcd_err = 1'b0;
`endif

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign a_d       = a_d_q;
  assign cs        = cs_q;
  assign rd        = rd_q;
  assign wr        = wr_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_rtc_burst_reader.sv
// Self-checking bench for rtc_burst_reader (default parameters); RAM writes checked against a scoreboard queue.
module tb_rtc_burst_reader;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] ad_in, ad_out, ram_wdata;
  logic [3:0] ram_addr;
  logic       ad_oe, a_d, cs, rd, wr, ram_we, busy, done, aborted, bcd_err;

`ifdef RTC_BCD_CHECK_EN
  localparam logic BCD_ON = 1'b1;
`else
  localparam logic BCD_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  errors = 0;
  int  checks = 0;

  rtc_burst_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .busy(busy), .done(done), .aborted(aborted), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  // RAM write scoreboard and bus contention watch.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (!cs && !rd && !wr) begin
        errors++;
        $display("FAIL bus_rule: cs,rd,wr all low at %0t", $time);
      end
      if (ram_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ram_write: unexpected write addr=%0h data=%0h", ram_addr, ram_wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({ram_addr, ram_wdata} !== mon_exp) begin
            errors++;
            $display("FAIL ram_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                     ram_addr, ram_wdata, mon_exp.addr, mon_exp.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; ad_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_d, cs, rd, wr, ad_oe, ad_out} !== {4'hF, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_bus: got %0h expected %0h", {a_d, cs, rd, wr, ad_oe, ad_out}, 13'h1E00);
    end
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== 13'h0) begin
      errors++;
      $display("FAIL reset_ram: got %0h expected 0", {ram_we, ram_addr, ram_wdata});
    end
    checks++;
    if ({busy, done, aborted, bcd_err} !== 4'h0) begin
      errors++;
      $display("FAIL reset_status: got %0h expected 0", {busy, done, aborted, bcd_err});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst();
    logic [7:0] vals [3];
    logic [7:0] exp_ad;
    int vi = 0, rd_low = 0, wr_low = 0, ad_low = 0;
    vals[0] = 8'h59; vals[1] = 8'h30; vals[2] = 8'h12;
    ad_in = vals[0];
    for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), vals[i]});
    start = 1'b1;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      checks++;
      if (done !== (cyc == 64)) begin
        errors++;
        $display("FAIL burst_done cyc %0d: got %b expected %b", cyc, done, cyc == 64);
      end
      checks++;
      if (busy !== (cyc <= 64)) begin
        errors++;
        $display("FAIL burst_busy cyc %0d: got %b expected %b", cyc, busy, cyc <= 64);
      end
      if (!rd) rd_low++;
      if (!wr) wr_low++;
      if (!a_d) ad_low++;
      if (cyc == 1 || cyc == 22 || cyc == 43) begin
        exp_ad = 8'h21 + 8'((cyc - 1) / 21);
        checks++;
        if ({ad_out, ad_oe, cs, a_d, wr, rd} !== {exp_ad, 5'b10001}) begin
          errors++;
          $display("FAIL addr_phase cyc %0d: got %0h expected %0h", cyc,
                   {ad_out, ad_oe, cs, a_d, wr, rd}, {exp_ad, 5'b10001});
        end
      end
      if (cyc == 8 || cyc == 9) begin
        checks++;
        if ({a_d, wr, ad_oe} !== ((cyc == 8) ? 3'b001 : 3'b110)) begin
          errors++;
          $display("FAIL addr_end cyc %0d: got %b", cyc, {a_d, wr, ad_oe});
        end
      end
      if (cyc == 11 || cyc == 18 || cyc == 19) begin
        checks++;
        if ({cs, rd, a_d, ad_oe, ram_we} !== ((cyc == 19) ? 5'b11101 : 5'b00100)) begin
          errors++;
          $display("FAIL data_phase cyc %0d: got %b", cyc, {cs, rd, a_d, ad_oe, ram_we});
        end
      end
      if (ram_we && vi < 2) begin
        vi++;
        ad_in = vals[vi];
      end
    end
    checks++;
    if ({rd_low, wr_low, ad_low} !== {32'd24, 32'd24, 32'd24}) begin
      errors++;
      $display("FAIL strobe_counts: got rd=%0d wr=%0d a_d=%0d expected 24 each", rd_low, wr_low, ad_low);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort();
    ad_in = 8'h11;
    exp_q.push_back({4'h0, 8'h11});
    start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 34) abort = 1'b1;
      if (cyc == 35) begin
        abort = 1'b0;
        checks++;
        if ({done, aborted, busy, a_d, cs, rd, wr, ad_oe, ram_we} !== 9'b111111100) begin
          errors++;
          $display("FAIL abort_done: got %b expected 111111100",
                   {done, aborted, busy, a_d, cs, rd, wr, ad_oe, ram_we});
        end
      end
      if (cyc == 36) begin
        checks++;
        if ({done, aborted, busy} !== 3'b000) begin
          errors++;
          $display("FAIL abort_idle: got %b expected 000", {done, aborted, busy});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if ({busy, cs, a_d, done} !== 4'b1000) begin
          errors++;
          $display("FAIL start_wins: got %b expected 1000", {busy, cs, a_d, done});
        end
        start = 1'b0; abort = 1'b0;
      end
      if (cyc == 3) abort = 1'b1;
      if (cyc == 4) begin
        abort = 1'b0;
        checks++;
        if ({done, aborted, cs} !== 3'b111) begin
          errors++;
          $display("FAIL abort_in_addr: got %b expected 111", {done, aborted, cs});
        end
      end
      if (cyc == 5) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_in_addr_idle: busy got %b expected 0", busy);
        end
      end
    end
  endtask

  task automatic test_start_held();
    ad_in = 8'h42;
    for (int i = 0; i < 6; i++) exp_q.push_back({4'(i % 3), 8'h42});
    start = 1'b1;
    for (int cyc = 1; cyc <= 131; cyc++) begin
      @(negedge clk);
      checks++;
      if (done !== (cyc == 64 || cyc == 129)) begin
        errors++;
        $display("FAIL held_done cyc %0d: got %b", cyc, done);
      end
      if (cyc == 22) begin
        checks++;
        if (ad_out !== 8'h22) begin
          errors++;
          $display("FAIL held_no_restart: ad_out got %0h expected 22", ad_out);
        end
      end
      if (cyc == 65 || cyc == 66) begin
        checks++;
        if ({busy, cs} !== ((cyc == 65) ? 2'b01 : 2'b10) || (cyc == 66 && ad_out !== 8'h21)) begin
          errors++;
          $display("FAIL held_restart cyc %0d: got busy=%b cs=%b ad_out=%0h", cyc, busy, cs, ad_out);
        end
        if (cyc == 66) start = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    ad_in = 8'h77;
    exp_q.push_back({4'h0, 8'h77});
    exp_q.push_back({4'h1, 8'h77});
    start = 1'b1;
    for (int cyc = 1; cyc <= 41; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    checks++;
    if ({busy, ram_we, cs} !== 3'b101) begin
      errors++;
      $display("FAIL pre_reset_gap2: got %b expected 101", {busy, ram_we, cs});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a_d, cs, rd, wr, ad_oe, ad_out, ram_we, ram_addr, ram_wdata, busy, done, aborted, bcd_err}
        !== {4'hF, 26'h0}) begin
      errors++;
      $display("FAIL reset_mid: got %0h expected %0h",
               {a_d, cs, rd, wr, ad_oe, ad_out, ram_we, ram_addr, ram_wdata, busy, done, aborted, bcd_err},
               {4'hF, 26'h0});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: busy/done seen %0d cycles expected 0", done_seen);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bcd();
    ad_in = 8'h5A;
    for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), 8'h5A});
    start = 1'b1;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 18) begin
        checks++;
        if (bcd_err !== 1'b0) begin
          errors++;
          $display("FAIL bcd_before_store: got %b expected 0", bcd_err);
        end
      end
      if (cyc == 19 || cyc == 66) begin
        checks++;
        if (bcd_err !== BCD_ON) begin
          errors++;
          $display("FAIL bcd_set cyc %0d: got %b expected %b", cyc, bcd_err, BCD_ON);
        end
      end
    end
    ad_in = 8'h12;
    for (int i = 0; i < 3; i++) exp_q.push_back({4'(i), 8'h12});
    start = 1'b1;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        checks++;
        if (bcd_err !== 1'b0) begin
          errors++;
          $display("FAIL bcd_clear: got %b expected 0", bcd_err);
        end
      end
      if (cyc == 66) begin
        checks++;
        if (bcd_err !== 1'b0) begin
          errors++;
          $display("FAIL bcd_valid: got %b expected 0", bcd_err);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bcd_writes: %0d writes missing, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    repeat (2) @(negedge clk);
    test_abort();
    repeat (2) @(negedge clk);
    test_start_abort();
    repeat (2) @(negedge clk);
    test_start_held();
    repeat (2) @(negedge clk);
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_bcd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
